// File: rtl/fpu_host_seq.sv
// ============================================================================
// Module   : fpu_host_seq
// Purpose  : Bus initiator that loads A/B/opcode into the byte-wide FPU
//            register port, waits for end-of-command and reads the result.
//            Optional WAIT_END timeout is built when FPU_HOST_TIMEOUT_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_host_seq #(
  parameter int STROBE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        req,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [7:0]  opcode,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] result,
  output logic [3:0]  fpu_addr,
  output logic [7:0]  fpu_dout,
  input  logic [7:0]  fpu_din,
  output logic        fpu_cs_n,
  output logic        fpu_wr_n,
  output logic        fpu_rd_n,
  input  logic        fpu_cmd_end,
  output logic        fpu_end_ack
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_W_SETUP  = 4'd1,
    S_W_STROBE = 4'd2,
    S_W_HOLD   = 4'd3,
    S_WAIT_END = 4'd4,
    S_R_SETUP  = 4'd5,
    S_R_STROBE = 4'd6,
    S_R_HOLD   = 4'd7,
    S_ACK      = 4'd8
  } state_t;

  localparam logic [3:0] c_STB_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] c_LAST_WR  = 4'd8;
  localparam logic [3:0] c_FIRST_RD = 4'd9;
  localparam logic [3:0] c_LAST_RD  = 4'd12;

  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("fpu_host_seq: STROBE_CYCLES must be 1..15 and TIMEOUT_CYCLES >= 1");
  end

`ifdef FPU_HOST_TIMEOUT_EN
  localparam int c_TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
  logic [c_TO_W-1:0] r_to_cnt;
`else
  assign error = 1'b0;
`endif

  state_t           r_state;
  logic [3:0]       r_idx;
  logic [3:0]       r_stb_cnt;
  logic [8:0][7:0]  r_wbyte;   // register-map order: A0..A3, B0..B3, opcode
  logic [3:0][7:0]  r_rbuf;    // result shadow, published to result on done
  logic [3:0]       w_next_idx;
  logic [1:0]       w_rsel;

  assign w_next_idx = r_idx + 4'd1;
  assign w_rsel     = 2'(r_idx - c_FIRST_RD);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= 4'd0;
      r_stb_cnt   <= 4'd0;
      r_wbyte     <= '0;
      r_rbuf      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= 32'd0;
      fpu_addr    <= 4'd0;
      fpu_dout    <= 8'd0;
      fpu_cs_n    <= 1'b1;
      fpu_wr_n    <= 1'b1;
      fpu_rd_n    <= 1'b1;
      fpu_end_ack <= 1'b0;
`ifdef FPU_HOST_TIMEOUT_EN
      error       <= 1'b0;
      r_to_cnt    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_wbyte  <= {opcode, op_b, op_a};
            r_idx    <= 4'd0;
            busy     <= 1'b1;
            fpu_cs_n <= 1'b0;
            fpu_wr_n <= 1'b1;
            fpu_addr <= 4'd0;
            fpu_dout <= op_a[7:0];
            r_state  <= S_W_SETUP;
          end else begin
            busy <= 1'b0;
          end
        end
        S_W_SETUP: begin
          fpu_wr_n  <= 1'b0;
          r_stb_cnt <= c_STB_LAST;
          r_state   <= S_W_STROBE;
        end
        S_W_STROBE: begin
          if (r_stb_cnt == 4'd0) begin
            fpu_wr_n <= 1'b1;
            r_state  <= S_W_HOLD;
          end else begin
            r_stb_cnt <= r_stb_cnt - 4'd1;
          end
        end
        S_W_HOLD: begin
          if (r_idx < c_LAST_WR) begin
            r_idx    <= w_next_idx;
            fpu_addr <= w_next_idx;
            fpu_dout <= r_wbyte[w_next_idx];
            r_state  <= S_W_SETUP;
          end else begin
            fpu_cs_n <= 1'b1;
            r_state  <= S_WAIT_END;
`ifdef FPU_HOST_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
          end
        end
        S_WAIT_END: begin
          if (fpu_cmd_end) begin
            r_idx    <= c_FIRST_RD;
            fpu_addr <= c_FIRST_RD;
            fpu_cs_n <= 1'b0;
            r_state  <= S_R_SETUP;
          end
`ifdef FPU_HOST_TIMEOUT_EN
          else if (r_to_cnt == c_TO_LAST) begin
            done    <= 1'b1;
            error   <= 1'b1;
            result  <= 32'd0;
            r_state <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end
        S_R_SETUP: begin
          fpu_rd_n  <= 1'b0;
          r_stb_cnt <= c_STB_LAST;
          r_state   <= S_R_STROBE;
        end
        S_R_STROBE: begin
          if (r_stb_cnt == 4'd0) begin
            r_rbuf[w_rsel] <= fpu_din;
            fpu_rd_n       <= 1'b1;
            r_state        <= S_R_HOLD;
          end else begin
            r_stb_cnt <= r_stb_cnt - 4'd1;
          end
        end
        S_R_HOLD: begin
          if (r_idx < c_LAST_RD) begin
            r_idx    <= w_next_idx;
            fpu_addr <= w_next_idx;
            r_state  <= S_R_SETUP;
          end else begin
            fpu_cs_n    <= 1'b1;
            fpu_end_ack <= 1'b1;
            r_state     <= S_ACK;
          end
        end
        S_ACK: begin
          if (!fpu_cmd_end) begin
            fpu_end_ack <= 1'b0;
            done        <= 1'b1;
            result      <= r_rbuf;
`ifdef FPU_HOST_TIMEOUT_EN
            error       <= 1'b0;
`endif
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpu_host_seq.sv
// ============================================================================
// Module   : tb_fpu_host_seq
// Purpose  : Directed bench for fpu_host_seq with a byte-wide FPU bus model.
//            Timeout vectors run only when FPU_HOST_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_host_seq;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [7:0]  opcode = '0;
  logic        busy, done, error;
  logic [31:0] result;
  logic [3:0]  fpu_addr;
  logic [7:0]  fpu_dout, fpu_din;
  logic        fpu_cs_n, fpu_wr_n, fpu_rd_n, fpu_end_ack;
  logic        fpu_cmd_end = 1'b0;

  always #5 clk = ~clk;

  fpu_host_seq #(.STROBE_CYCLES(3), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .arst_n(arst_n), .req(req), .op_a(op_a), .op_b(op_b),
    .opcode(opcode), .busy(busy), .done(done), .error(error), .result(result),
    .fpu_addr(fpu_addr), .fpu_dout(fpu_dout), .fpu_din(fpu_din),
    .fpu_cs_n(fpu_cs_n), .fpu_wr_n(fpu_wr_n), .fpu_rd_n(fpu_rd_n),
    .fpu_cmd_end(fpu_cmd_end), .fpu_end_ack(fpu_end_ack)
  );

  // ---------------- FPU bus model ----------------
  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    int         width;
    bit         stable;
  } wr_t;

  wr_t         wlog[$];
  logic [7:0]  m_reg [0:15];
  logic [31:0] m_res = 32'd0;
  logic        m_prev_wr = 1'b1, m_prev_rd = 1'b1;
  logic [3:0]  m_cap_a = '0;
  logic [7:0]  m_cap_d = '0;
  int          m_w = 0, m_timer = 0, m_ackcnt = 0;
  bit          m_st = 1'b1, m_pend = 1'b0;
  int          done_cnt = 0, read_cnt = 0, ack_cyc = 0, viol = 0;
  bit          cmd_en = 1'b1;
  int          cmd_delay = 10, ack_hold = 1;

  always_comb begin
    case (fpu_addr)
      4'd9:    fpu_din = m_res[7:0];
      4'd10:   fpu_din = m_res[15:8];
      4'd11:   fpu_din = m_res[23:16];
      4'd12:   fpu_din = m_res[31:24];
      default: fpu_din = 8'hEE;
    endcase
  end

  always @(negedge clk) begin
    logic [31:0] ma, mb;
    if (!fpu_wr_n && !fpu_rd_n) viol++;
    if ((!fpu_wr_n || !fpu_rd_n) && fpu_cs_n) viol++;
    if (done) done_cnt++;
    if (!fpu_rd_n && m_prev_rd) read_cnt++;
    if (fpu_end_ack) ack_cyc++;
    if (m_pend) begin
      if (m_timer > 0) m_timer--;
      if (m_timer == 0) begin fpu_cmd_end = 1'b1; m_pend = 1'b0; end
    end
    if (!fpu_wr_n) begin
      if (m_prev_wr) begin
        m_cap_a = fpu_addr; m_cap_d = fpu_dout; m_w = 1; m_st = 1'b1;
      end else begin
        m_w++;
        if (fpu_addr !== m_cap_a || fpu_dout !== m_cap_d) m_st = 1'b0;
      end
    end else if (!m_prev_wr) begin
      wlog.push_back('{m_cap_a, m_cap_d, m_w, m_st});
      m_reg[m_cap_a] = m_cap_d;
      if (m_cap_a == 4'd8) begin
        ma = {m_reg[3], m_reg[2], m_reg[1], m_reg[0]};
        mb = {m_reg[7], m_reg[6], m_reg[5], m_reg[4]};
        // equal operands: real FP doubling (exponent + 1); otherwise a tag value
        m_res = (ma == mb) ? ma + 32'h0080_0000 : ma ^ mb;
        if (cmd_en) begin m_pend = 1'b1; m_timer = cmd_delay; end
      end
    end
    if (fpu_end_ack) begin
      m_ackcnt++;
      if (m_ackcnt >= ack_hold) fpu_cmd_end = 1'b0;
    end else begin
      m_ackcnt = 0;
    end
    m_prev_wr = fpu_wr_n;
    m_prev_rd = fpu_rd_n;
  end

  // ---------------- checking helpers ----------------
  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op);
    @(negedge clk);
    op_a = a; op_b = b; opcode = op; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("busy_rise", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
  endtask

  task automatic check_log(input string tag, input int base, input logic [71:0] bytes);
    check({tag, "_nwrites"}, 32'(wlog.size() - base), 32'd9);
    for (int i = 0; i < 9; i++) begin
      if (base + i < wlog.size()) begin
        check($sformatf("%s_addr%0d", tag, i), {28'd0, wlog[base+i].addr}, 32'(i));
        check($sformatf("%s_data%0d", tag, i), {24'd0, wlog[base+i].data}, {24'd0, bytes[i*8 +: 8]});
        check($sformatf("%s_strobe%0d", tag, i),
              {wlog[base+i].width[30:0], wlog[base+i].stable}, {31'd3, 1'b1});
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base, dbase, rbase, abase, k, w;
    logic [71:0] exp_bytes;

    #12;
    check("rst_busy",   {31'd0, busy},        32'd0);
    check("rst_done",   {31'd0, done},        32'd0);
    check("rst_error",  {31'd0, error},       32'd0);
    check("rst_result", result,               32'd0);
    check("rst_addr_dout", {20'd0, fpu_addr, fpu_dout}, 32'd0);
    check("rst_strobes", {28'd0, fpu_cs_n, fpu_wr_n, fpu_rd_n, fpu_end_ack}, 32'b1110);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);

    // write ordering and 3-cycle strobes
    base = wlog.size(); dbase = done_cnt;
    start_op(32'h1122_3344, 32'h5566_7788, 8'h01);
    wait_done("seq");
    check("seq_error",  {31'd0, error}, 32'd0);
    check("seq_result", result, 32'h4444_44CC);
    exp_bytes = 72'h01_55667788_11223344;
    check_log("seq", base, exp_bytes);
    @(negedge clk);
    check("seq_done_width", {31'd0, done}, 32'd0);
    check("seq_done_count", 32'(done_cnt - dbase), 32'd1);

    // normal FP add of equal operands
    dbase = done_cnt;
    start_op(32'h43A9_AB64, 32'h43A9_AB64, 8'h01);
    wait_done("add");
    check("add_error",  {31'd0, error}, 32'd0);
    check("add_result", result, 32'h4429_AB64);
    repeat (3) @(negedge clk);
    check("add_done_count", 32'(done_cnt - dbase), 32'd1);
    check("add_busy_fall", {31'd0, busy}, 32'd0);

    // request during write phase is ignored
    base = wlog.size(); dbase = done_cnt;
    start_op(32'hA5A5_A5A5, 32'h5A5A_5A5A, 8'h02);
    repeat (10) @(negedge clk);
    op_a = 32'hDEAD_BEEF; op_b = 32'h0BAD_F00D; opcode = 8'h77; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_done("ign");
    check("ign_result", result, 32'hFFFF_FFFF);
    exp_bytes = 72'h02_5A5A5A5A_A5A5A5A5;
    check_log("ign", base, exp_bytes);
    repeat (60) @(negedge clk);
    check("ign_done_count", 32'(done_cnt - dbase), 32'd1);

    // cmd_end held for 5 cycles after end_ack
    ack_hold = 5;
    start_op(32'h3F80_0000, 32'h3F80_0000, 8'h01);
    k = 0;
    while (fpu_end_ack !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    check("ack_seen", {31'd0, fpu_end_ack}, 32'd1);
    w = 0;
    do begin w++; @(negedge clk); end while (fpu_end_ack === 1'b1 && w < 50);
    check("ack_width", 32'(w), 32'd5);
    check("ack_done_with_fall", {31'd0, done}, 32'd1);
    check("ack_result", result, 32'h4000_0000);
    ack_hold = 1;

    // asynchronous reset during byte 5
    start_op(32'hCAFE_0001, 32'hCAFE_0002, 8'h05);
    k = 0;
    while (!(fpu_addr === 4'd5 && fpu_wr_n === 1'b0) && k < 200) begin @(negedge clk); k++; end
    check("rst_mid_reached", {28'd0, fpu_addr}, 32'd5);
    #1 arst_n = 1'b0;
    #1;
    check("rst_mid_cs",   {31'd0, fpu_cs_n}, 32'd1);
    check("rst_mid_wr",   {31'd0, fpu_wr_n}, 32'd1);
    check("rst_mid_rd",   {31'd0, fpu_rd_n}, 32'd1);
    check("rst_mid_busy", {31'd0, busy},     32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (3) @(negedge clk);
    base = wlog.size();
    start_op(32'h0102_0304, 32'h0506_0708, 8'h03);
    wait_done("restart");
    check("restart_result", result, 32'h0404_040C);
    exp_bytes = 72'h03_05060708_01020304;
    check_log("restart", base, exp_bytes);

`ifdef FPU_HOST_TIMEOUT_EN
    // cmd_end never arrives
    cmd_en = 1'b0;
    rbase = read_cnt; abase = ack_cyc;
    start_op(32'h1234_5678, 32'h0000_0000, 8'h04);
    k = 0;
    while (!(fpu_addr === 4'd8 && fpu_wr_n === 1'b0) && k < 200) begin @(negedge clk); k++; end
    k = 0;
    while (fpu_cs_n !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    w = 0;
    while (done !== 1'b1 && w < 100) begin w++; @(negedge clk); end
    check("to_wait_cycles", 32'(w), 32'd16);
    check("to_done",   {31'd0, done},  32'd1);
    check("to_error",  {31'd0, error}, 32'd1);
    check("to_result", result, 32'd0);
    check("to_no_reads", 32'(read_cnt - rbase), 32'd0);
    check("to_no_ack",   32'(ack_cyc - abase),  32'd0);
    cmd_en = 1'b1;
`endif

    repeat (2) @(negedge clk);
    check("protocol_violations", 32'(viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fpu_host_seq.md
# fpu_host_seq

Hardware bus initiator for the 8-bit FPU register interface. It accepts two 32-bit operands and an opcode from a host-side request port, then drives the byte-wide chip-select/strobe protocol to load operand A, operand B and the opcode. It waits for the FPU's end-of-command signal, reads the 32-bit result back, and completes the end acknowledge handshake. It sits between a CPU-side or DMA-side controller and the FPU, replacing software bit-banging of the FPU registers.

## Interface
- `STROBE_CYCLES`, default 1: number of cycles `fpu_wr_n` / `fpu_rd_n` are held low per byte; legal range 1–15.
- `TIMEOUT_CYCLES`, default 1024: wait limit for `fpu_cmd_end`. Used only with `FPU_HOST_TIMEOUT_EN`.
- `clk` in 1: single clock; all logic on the rising edge.
- `arst_n` in 1: asynchronous, active-low reset.
- `req` in 1: start request; sampled only in IDLE.
- `op_a` in 32: operand A; latched when `req` is accepted.
- `op_b` in 32: operand B; latched when `req` is accepted.
- `opcode` in 8: FPU operation code; latched when `req` is accepted.
- `busy` out 1: high from the cycle after acceptance until `done`.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: valid with `done`; 1 means timeout.
- `result` out 32: registered result; holds until the next `done`.
- `fpu_addr` out 4: FPU register address.
- `fpu_dout` out 8: write data to the FPU `databus_in`.
- `fpu_din` in 8: read data from the FPU `databus_out`.
- `fpu_cs_n` out 1: chip select, active low.
- `fpu_wr_n` out 1: write strobe, active low.
- `fpu_rd_n` out 1: read strobe, active low.
- `fpu_cmd_end` in 1: FPU end-of-command, active high.
- `fpu_end_ack` out 1: end acknowledge, active high.

## Operation
- **Register map.**
  - 0–3: operand A bytes, LSB first.
  - 4–7: operand B bytes, LSB first.
  - 8: opcode. Writing it starts the FPU.
  - 9–C: result bytes, LSB first.
- **States:** IDLE, W_SETUP, W_STROBE, W_HOLD, WAIT_END, R_SETUP, R_STROBE, R_HOLD, ACK.
- **IDLE**
  - If `req`=1: latch `op_a`, `op_b` and `opcode`, set byte index to 0, go to W_SETUP.
  - `req` in any other state is ignored and is not queued.
- **W_SETUP**
  - `fpu_cs_n`=0, `fpu_addr`=index, `fpu_dout`=selected byte, `fpu_wr_n`=1.
  - Then go to W_STROBE.
- **W_STROBE**
  - `fpu_wr_n`=0 for exactly `STROBE_CYCLES` cycles; addr and data stable.
  - Then go to W_HOLD.
- **W_HOLD**
  - `fpu_wr_n`=1; addr and data stable; `fpu_cs_n` stays 0.
  - index<8: increment index, go to W_SETUP.
  - index=8: go to WAIT_END.
- **WAIT_END**
  - `fpu_cs_n`=1.
  - When `fpu_cmd_end`=1 is sampled: set index to 9, go to R_SETUP.
- **R_SETUP**
  - `fpu_cs_n`=0, `fpu_addr`=index, `fpu_rd_n`=1.
- **R_STROBE**
  - `fpu_rd_n`=0 for `STROBE_CYCLES` cycles.
  - `fpu_din` is captured into result byte (index−9) at the last strobe cycle's closing edge.
- **R_HOLD**
  - `fpu_rd_n`=1.
  - index<C: increment index, go to R_SETUP.
  - index=C: go to ACK.
- **ACK**
  - `fpu_cs_n`=1, `fpu_end_ack`=1.
  - When `fpu_cmd_end`=0 is sampled: drop `fpu_end_ack`, pulse `done` (`error`=0), go to IDLE.
  - If `fpu_cmd_end` is already low on entry, ACK lasts 1 cycle.
- **Output rules.**
  - `fpu_wr_n` and `fpu_rd_n` are never low at the same time.
  - Strobes go low only while `fpu_cs_n`=0.
  - All FPU-side outputs are registered, so there are no glitches.
- **Reset.** Assertion mid-operation forces the idle output values immediately (asynchronous) and returns to IDLE. The latched operands are discarded.

## Timing
- **Reset values:**
  - `busy`, `done`, `error`, `fpu_wr_n`=… see below: `busy`=0, `done`=0, `error`=0, `result`=0.
  - `fpu_addr`=0, `fpu_dout`=0.
  - `fpu_cs_n`=1, `fpu_wr_n`=1, `fpu_rd_n`=1, `fpu_end_ack`=0.
- **Byte cost:** each byte, read or write, takes `STROBE_CYCLES`+2 cycles.
- **Write phase:** 9×(`STROBE_CYCLES`+2) cycles, which is 27 at the default.
- **Read phase:** 4×(`STROBE_CYCLES`+2) cycles, which is 12 at the default.
- **Total latency:** from the `req` sample edge to `done` = 1 + write phase + WAIT_END cycles + read phase + ACK cycles.
- **`busy`:** rises on the edge that accepts `req` and falls on the edge after `done`.
- **Back-to-back:** a `req` held high during the `done` cycle is accepted on the next edge.
- **`fpu_cmd_end`:** treated as a level, same clock domain, no synchronizer.

## Configuration
- **`FPU_HOST_TIMEOUT_EN` defined:**
  - WAIT_END counts cycles.
  - If `fpu_cmd_end` is still 0 after `TIMEOUT_CYCLES` cycles: pulse `done` with `error`=1 and set `result`=0.
  - The read and ACK phases are skipped; the block returns to IDLE.
  - The counter clears on every entry to WAIT_END.
- **`FPU_HOST_TIMEOUT_EN` undefined:**
  - No counter is built; WAIT_END waits indefinitely.
  - `error` is tied to 0.

## Test plan
- **Normal operation:** `op_a`=`op_b`=0x43A9AB64, `opcode`=add, FPU model asserts `cmd_end` 10 cycles after the opcode write. Required: `result`=0x4429AB64, `error`=0, exactly one `done` pulse.
- **Write sequence and strobe width:** `op_a`=0x11223344, `STROBE_CYCLES`=3. Required:
  - FPU model logs writes in the order addr0=0x44, addr1=0x33, addr2=0x22, addr3=0x11, then 4–7, then addr8=opcode.
  - Each `fpu_wr_n` low pulse is exactly 3 cycles with addr/data stable.
- **Ignored request:** `req` pulsed again during the write phase with different operands. Required: the FPU model sees only the first operand set; one `done`.
- **Acknowledge hold:** the model keeps `cmd_end` high 5 cycles after `end_ack` rises. Required: `end_ack` stays high 5 cycles, falls on the edge after `cmd_end` is seen low, and `done` coincides with that fall.
- **Reset mid-operation:** `arst_n` low during byte 5 of the write phase. Required:
  - `fpu_cs_n`, `fpu_wr_n` and `fpu_rd_n` go to 1 and `busy` to 0 without waiting for a clock edge.
  - A following `req` restarts cleanly from addr 0.
- **Timeout (`FPU_HOST_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16):** `cmd_end` is never asserted. Required:
  - `done`=1 with `error`=1 and `result`=0 after 16 WAIT_END cycles.
  - No read strobes and no `end_ack`.
